// File: rtl/capture_write_ctrl_pkg.sv
// Shared types and defaults for the capture write controller.
// State encoding is fixed because the MCU debug view decodes it.
package capture_write_ctrl_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE_FILL  = 3'd1,
    WAIT_TRIG = 3'd2,
    POST_FILL = 3'd3,
    DONE_ST   = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_down_counter.sv
// Loadable down-counter with enable, zero and one flags.
// Holds at zero rather than wrapping.
module capture_down_counter #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
  assign one  = (cnt_q == W'(1));

endmodule

// File: rtl/capture_write_ctrl.sv
// Sample-memory write sequencer: pre-fill, wait for trigger, post-fill.
// Optional CAPTURE_AUTO_TRIG_EN adds a strobe-count auto trigger.
module capture_write_ctrl
  import capture_write_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLK_EN,
  input  logic              START_WRITE,
  input  logic              TRIG_EV,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [ADDR_W-1:0] PRE_COUNT,
  input  logic [ADDR_W-1:0] POST_COUNT,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              BUSY,
  output logic              DONE
`ifdef CAPTURE_AUTO_TRIG_EN
  ,
  input  logic [15:0]       AUTO_TIMEOUT,
  output logic              AUTO_TRIGGED
`endif
);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] post_val;
  logic              pre_load, pre_dec, pre_zero, pre_one;
  logic              post_load, post_dec, post_zero, post_one;
  logic              busy_st, arm, strobe_wt, auto_fire, trig_hit;

  assign busy_st   = (state_q == PRE_FILL) || (state_q == WAIT_TRIG)
                   || (state_q == POST_FILL);
  assign arm       = (state_q == IDLE) && START_WRITE;
  assign strobe_wt = (state_q == WAIT_TRIG) && START_WRITE && CLK_EN;
  assign post_val  = (POST_COUNT == '0) ? '0 : POST_COUNT - ADDR_W'(1);

`ifdef CAPTURE_AUTO_TRIG_EN
  logic [15:0] auto_cnt_q, auto_cnt_d, auto_inc;
  logic        auto_trig_q, auto_trig_d;

  assign auto_inc  = auto_cnt_q + 16'd1;
  assign auto_fire = strobe_wt && (AUTO_TIMEOUT != 16'd0)
                   && (auto_inc == AUTO_TIMEOUT);

  always_comb begin
    auto_cnt_d  = auto_cnt_q;
    auto_trig_d = auto_trig_q;
    if (state_d == WAIT_TRIG && state_q != WAIT_TRIG) auto_cnt_d = '0;
    else if (strobe_wt) auto_cnt_d = auto_inc;
    if (arm) auto_trig_d = 1'b0;
    else if (auto_fire) auto_trig_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
    end else begin
      auto_cnt_q  <= auto_cnt_d;
      auto_trig_q <= auto_trig_d;
    end
  end

  assign AUTO_TRIGGED = auto_trig_q;
`else
  assign auto_fire = 1'b0;
`endif

  assign trig_hit = TRIG_EV || auto_fire;

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    trig_addr_d = trig_addr_q;
    pre_load    = 1'b0;
    pre_dec     = 1'b0;
    post_load   = 1'b0;
    post_dec    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (START_WRITE) begin
          addr_cnt_d = '0;
          pre_load   = 1'b1;
          state_d    = (PRE_COUNT != '0) ? PRE_FILL : WAIT_TRIG;
        end
      end
      busy_st: begin
        if (!START_WRITE) begin
          state_d = IDLE;
        end else if (CLK_EN) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = addr_cnt_q;
          wr_data_d  = DATA_IN;
          addr_cnt_d = addr_cnt_q + ADDR_W'(1);
          if (state_q == PRE_FILL) begin
            pre_dec = 1'b1;
            if (pre_one || pre_zero) state_d = WAIT_TRIG;
          end else if (state_q == WAIT_TRIG) begin
            if (trig_hit) begin
              trig_addr_d = addr_cnt_q;
              post_load   = 1'b1;
              state_d     = (post_val == '0) ? DONE_ST : POST_FILL;
            end
          end else begin
            post_dec = 1'b1;
            if (post_one || post_zero) state_d = DONE_ST;
          end
        end
      end
      (state_q == DONE_ST): begin
        if (!START_WRITE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == PRE_FILL) || (state_d == WAIT_TRIG)
                || (state_d == POST_FILL);
  assign done_d = (state_d == DONE_ST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      trig_addr_q <= trig_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  capture_down_counter #(.W(ADDR_W)) u_pre_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (pre_load),
    .load_val (PRE_COUNT),
    .dec      (pre_dec),
    .zero     (pre_zero),
    .one      (pre_one)
  );

  capture_down_counter #(.W(ADDR_W)) u_post_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (post_load),
    .load_val (post_val),
    .dec      (post_dec),
    .zero     (post_zero),
    .one      (post_one)
  );

  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign TRIG_ADDR = trig_addr_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_capture_write_ctrl.sv
// Scoreboard bench for capture_write_ctrl (ADDR_W=4 to exercise wrap).
// Define CAPTURE_AUTO_TRIG_EN to also cover the auto-trigger.
module tb_capture_write_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CLK_EN = 1'b0;
  logic          START_WRITE = 1'b0;
  logic          TRIG_EV = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
  logic [AW-1:0] PRE_COUNT = '0;
  logic [AW-1:0] POST_COUNT = '0;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic [AW-1:0] TRIG_ADDR;
  logic          BUSY;
  logic          DONE;
`ifdef CAPTURE_AUTO_TRIG_EN
  logic [15:0]   AUTO_TIMEOUT = '0;
  logic          AUTO_TRIGGED;
`endif

  capture_write_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .CLK_EN       (CLK_EN),
    .START_WRITE  (START_WRITE),
    .TRIG_EV      (TRIG_EV),
    .DATA_IN      (DATA_IN),
    .PRE_COUNT    (PRE_COUNT),
    .POST_COUNT   (POST_COUNT),
    .WR_EN        (WR_EN),
    .WR_ADDR      (WR_ADDR),
    .WR_DATA      (WR_DATA),
    .TRIG_ADDR    (TRIG_ADDR),
    .BUSY         (BUSY),
    .DONE         (DONE)
`ifdef CAPTURE_AUTO_TRIG_EN
    ,
    .AUTO_TIMEOUT (AUTO_TIMEOUT),
    .AUTO_TRIGGED (AUTO_TRIGGED)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           sb[$];
  logic [AW-1:0] exp_addr = '0;
  int            checks = 0;
  int            errors = 0;

  always @(negedge CLK) begin
    if (RST_N && WR_EN) begin
      wr_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%0h", WR_ADDR, WR_DATA);
      end else begin
        e = sb.pop_front();
        if (WR_ADDR !== e.a || WR_DATA !== e.d) begin
          errors++;
          $display("FAIL write got addr=%0d data=%0h want addr=%0d data=%0h",
                   WR_ADDR, WR_DATA, e.a, e.d);
        end
      end
    end
  end

  task automatic step(input logic en, input logic trig, input logic wr);
    CLK_EN  = en;
    TRIG_EV = trig;
    DATA_IN = DW'($urandom);
    if (wr) begin
      sb.push_back({exp_addr, DATA_IN});
      exp_addr++;
    end
    @(posedge CLK);
    #1;
    CLK_EN = 1'b0;
  endtask

  task automatic arm(input logic [AW-1:0] pre, input logic [AW-1:0] post);
    PRE_COUNT   = pre;
    POST_COUNT  = post;
    START_WRITE = 1'b1;
    CLK_EN      = 1'b1;
    exp_addr    = '0;
    @(posedge CLK);
    #1;
    CLK_EN = 1'b0;
  endtask

  task automatic release_done(input string name);
    START_WRITE = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_release done=%b busy=%b want 0 0", name, DONE, BUSY);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({WR_EN, WR_ADDR, WR_DATA, TRIG_ADDR, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL reset en=%b addr=%0d data=%0h trig=%0d busy=%b done=%b want 0",
               WR_EN, WR_ADDR, WR_DATA, TRIG_ADDR, BUSY, DONE);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    arm(4'd4, 4'd3);
    PRE_COUNT = 4'd1;
    for (int s = 1; s <= 8; s++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, s >= 6, 1'b1);
      if (s == 6) POST_COUNT = 4'd15;
      if (s == 7) begin
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
          errors++;
          $display("FAIL basic_mid busy=%b done=%b want 1 0", BUSY, DONE);
        end
      end
    end
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%b busy=%b want 1 0", DONE, BUSY);
    end
    checks++;
    if (TRIG_ADDR !== 4'd5) begin
      errors++;
      $display("FAIL basic_trig_addr got %0d want 5", TRIG_ADDR);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_hold done=%b want 1", DONE);
    end
    release_done("basic");
  endtask

  task automatic test_sync_off();
    arm(4'd2, 4'd0);
    for (int s = 1; s <= 3; s++) step(1'b1, 1'b1, 1'b1);
    checks++;
    if (DONE !== 1'b1 || TRIG_ADDR !== 4'd2) begin
      errors++;
      $display("FAIL sync_off done=%b trig=%0d want 1 2", DONE, TRIG_ADDR);
    end
    step(1'b1, 1'b1, 1'b0);
    release_done("sync_off");
  endtask

  task automatic test_pre_ignore();
    arm(4'd10, 4'd1);
    for (int s = 1; s <= 12; s++) begin
      step(1'b1, (s == 3) || (s == 12), 1'b1);
      if (s == 11) begin
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
          errors++;
          $display("FAIL pre_ignore_mid busy=%b done=%b want 1 0", BUSY, DONE);
        end
      end
    end
    checks++;
    if (DONE !== 1'b1 || TRIG_ADDR !== 4'd11) begin
      errors++;
      $display("FAIL pre_ignore done=%b trig=%0d want 1 11", DONE, TRIG_ADDR);
    end
    release_done("pre_ignore");
  endtask

  task automatic test_wrap();
    arm(4'd0, 4'd2);
    for (int s = 1; s <= 21; s++) step(1'b1, s == 20, 1'b1);
    checks++;
    if (DONE !== 1'b1 || TRIG_ADDR !== 4'd3) begin
      errors++;
      $display("FAIL wrap done=%b trig=%0d want 1 3", DONE, TRIG_ADDR);
    end
    release_done("wrap");
  endtask

  task automatic test_abort_reset();
    arm(4'd0, 4'd5);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    START_WRITE = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({WR_EN, BUSY, DONE} !== 3'b000 || TRIG_ADDR !== 4'd1) begin
      errors++;
      $display("FAIL abort en=%b busy=%b done=%b trig=%0d want 0 0 0 1",
               WR_EN, BUSY, DONE, TRIG_ADDR);
    end
    step(1'b1, 1'b1, 1'b0);
    release_done("abort");
    arm(4'd0, 4'd1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    #5;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({WR_EN, BUSY, DONE} !== 3'b000 || TRIG_ADDR !== '0) begin
      errors++;
      $display("FAIL async_reset en=%b busy=%b done=%b trig=%0d want 0 0 0 0",
               WR_EN, BUSY, DONE, TRIG_ADDR);
    end
    step(1'b1, 1'b1, 1'b0);
    START_WRITE = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    RST_N = 1'b1;
    release_done("reset");
  endtask

`ifdef CAPTURE_AUTO_TRIG_EN
  task automatic test_auto();
    AUTO_TIMEOUT = 16'd5;
    arm(4'd0, 4'd1);
    for (int s = 1; s <= 5; s++) begin
      step(1'b1, 1'b0, 1'b1);
      if (s == 4) begin
        checks++;
        if (BUSY !== 1'b1 || AUTO_TRIGGED !== 1'b0) begin
          errors++;
          $display("FAIL auto_mid busy=%b auto=%b want 1 0", BUSY, AUTO_TRIGGED);
        end
      end
    end
    checks++;
    if (DONE !== 1'b1 || TRIG_ADDR !== 4'd4 || AUTO_TRIGGED !== 1'b1) begin
      errors++;
      $display("FAIL auto done=%b trig=%0d auto=%b want 1 4 1",
               DONE, TRIG_ADDR, AUTO_TRIGGED);
    end
    release_done("auto");
    AUTO_TIMEOUT = 16'd0;
    arm(4'd0, 4'd1);
    checks++;
    if (AUTO_TRIGGED !== 1'b0) begin
      errors++;
      $display("FAIL auto_clear got %b want 0", AUTO_TRIGGED);
    end
    release_done("auto_clear");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sync_off();
    test_pre_ignore();
    test_wrap();
    test_abort_reset();
`ifdef CAPTURE_AUTO_TRIG_EN
    test_auto();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_write_ctrl.md
Name: capture_write_ctrl

Overview:
Consumer end of the trigger-event interface. Receives the trigger event produced by the synchronization block and drives sample memory writes. It writes a programmable pre-trigger window, then writes circularly until a trigger. After the trigger it writes a programmable post-trigger window, latches the trigger address and reports completion. It sits between the sync/trigger logic and the sample SRAM port read back by the MCU.

Parameters:
ADDR_W, 15, sample memory address width; address counter wraps modulo 2^ADDR_W.
DATA_W, 8, sample width.

Ports:
CLK  in  1  system clock.
RST_N  in  1  asynchronous active-low reset.
CLK_EN  in  1  sample strobe; one sample per CLK cycle with CLK_EN=1.
START_WRITE  in  1  arm level; high = capture requested; low = abort / acknowledge done.
TRIG_EV  in  1  trigger event from sync block; held 1 when sync is globally off.
DATA_IN  in  DATA_W  sample data.
PRE_COUNT  in  ADDR_W  pre-trigger samples to write before trigger is honoured.
POST_COUNT  in  ADDR_W  samples written from the trigger sample onwards; 0 treated as 1.
WR_EN  out  1  memory write strobe, one CLK wide.
WR_ADDR  out  ADDR_W  write address.
WR_DATA  out  DATA_W  write data.
TRIG_ADDR  out  ADDR_W  address at which the trigger sample was written.
BUSY  out  1  capture in progress (PRE_FILL, WAIT_TRIG, POST_FILL).
DONE  out  1  capture complete.

Behaviour:
- Reset (RST_N=0, async): state IDLE. WR_EN, WR_ADDR, WR_DATA, TRIG_ADDR, BUSY, DONE and all internal counters are 0.
- States: IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE_ST.
- IDLE and START_WRITE=1:
  - addr_cnt <= 0 and pre_cnt <= PRE_COUNT.
  - Next state is PRE_FILL if PRE_COUNT != 0, else WAIT_TRIG.
  - No write occurs on the arming cycle.
- Write rule, in PRE_FILL, WAIT_TRIG and POST_FILL only, on an edge with CLK_EN=1:
  - WR_EN <= 1, WR_ADDR <= addr_cnt, WR_DATA <= DATA_IN, addr_cnt <= addr_cnt+1 (wraps).
  - On every other edge WR_EN <= 0, and WR_ADDR/WR_DATA hold.
  - Latency: strobe cycle to WR_EN is exactly one CLK.
- PRE_FILL: each strobe writes and decrements pre_cnt. The strobe that takes pre_cnt 1->0 moves to WAIT_TRIG. TRIG_EV is ignored here.
- WAIT_TRIG: each strobe writes.
  - A strobe with TRIG_EV=1 latches TRIG_ADDR <= addr_cnt (the trigger sample's own address).
  - On that strobe, post_cnt <= max(POST_COUNT,1)-1.
  - Go to DONE_ST if that value is 0, else POST_FILL.
  - TRIG_EV without CLK_EN is ignored.
- POST_FILL: each strobe writes and decrements post_cnt. The strobe taking 1->0 goes to DONE_ST.
- DONE_ST: DONE=1, no writes. Returns to IDLE when START_WRITE=0, and DONE clears on that same edge.
- START_WRITE=0 in any BUSY state aborts to IDLE on the next edge with no write. TRIG_ADDR keeps its last value.
- BUSY and DONE are registered and decoded from the state.
- Wrap-around: when the total writes exceed 2^ADDR_W, older samples are overwritten. The MCU reconstructs order from TRIG_ADDR.
- PRE_COUNT and POST_COUNT are sampled only at arm (pre_cnt) and at trigger (post_cnt). Changes during capture take effect on the next capture.

Optional Feature:
CAPTURE_AUTO_TRIG_EN:
- With the macro defined: adds input AUTO_TIMEOUT [15:0] and output AUTO_TRIGGED (1 bit).
  - A 16-bit counter clears on entry to WAIT_TRIG and counts strobes while in WAIT_TRIG.
  - When AUTO_TIMEOUT != 0 and the counter reaches AUTO_TIMEOUT on a strobe, that strobe is treated as TRIG_EV=1 and AUTO_TRIGGED <= 1.
  - AUTO_TRIGGED clears at arm and on reset.
- Without the macro: neither port exists, and WAIT_TRIG waits indefinitely.

Decomposition:
- Shared package/include holds the state encoding constants (3-bit: IDLE=0, PRE_FILL=1, WAIT_TRIG=2, POST_FILL=3, DONE_ST=4) and the default ADDR_W/DATA_W.
- One natural sub-module: capture_down_counter (loadable ADDR_W down-counter with enable and zero flag). It is instantiated twice, for pre_cnt and post_cnt.

Test Plan:
- Arm with PRE=4, POST=3, CLK_EN every 2nd cycle, TRIG_EV=0 until the 6th strobe, then 1 -> WR_ADDR 0..7 written. TRIG_ADDR=5, DONE after 8 writes, BUSY falls the same cycle.
- TRIG_EV held 1 (sync off), PRE=2, POST=0 -> 3 writes (addr 0,1,2), TRIG_ADDR=2, DONE.
- TRIG_EV pulse during PRE_FILL (PRE=10, pulse on strobe 3) -> ignored. A later trigger on strobe 12 gives TRIG_ADDR=11.
- ADDR_W=4, PRE=0, trigger on strobe 20 -> WR_ADDR wraps 15->0, TRIG_ADDR=3.
- Drop START_WRITE mid-POST_FILL, and assert RST_N=0 asynchronously mid-WAIT_TRIG -> IDLE, WR_EN=0 next edge (immediately for reset), DONE=0, no further writes.
- With CAPTURE_AUTO_TRIG_EN, AUTO_TIMEOUT=5, TRIG_EV=0, PRE=0 -> forced trigger on the 5th strobe, TRIG_ADDR=4, AUTO_TRIGGED=1.
